mmac_result_streamer: RTL and testbench

- Drains packed M_SIZE x M_SIZE result matrices from the matrix multiply/accumulate datapath.
- Serialises each matrix into one element per beat on a valid/ready stream, for an external memory writer or host FIFO.
- Double-buffered: the next matrix is accepted while the current one streams, so back-to-back matrices produce no bubble.
- Per-matrix selectable row-major or column-major order.

---
 rtl/mmac_pkg.sv | 32 +++
 rtl/mmac_result_streamer_if.sv | 31 +++
 rtl/mmac_matrix_buf.sv | 49 ++++
 rtl/mmac_result_streamer.sv | 129 ++++++++++++
 tb/tb_mmac_result_streamer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmac_pkg.sv
// Shared types and helpers for the matrix multiply/accumulate datapath.
// Latency: none (package only).
// Backpressure: n/a. Provides sizing constants, the streamer FSM state type and elem_sel().
package mmac_pkg;

  localparam int M_SIZE      = 4;
  localparam int VAR_WIDTH   = 8;
  localparam int DATA_WIDTH  = M_SIZE * M_SIZE * VAR_WIDTH;
  localparam int IDX_WIDTH   = 4;
  localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH);

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } streamer_state_t;

  // Element (r,c) lives at flat position r*M_SIZE+c counted from the MSB end,
  // so (0,0) is the top byte. Shifting left by the flat offset brings the
  // wanted element to the top, which avoids a wide variable part-select.
  function automatic logic [VAR_WIDTH-1:0] elem_sel(
    input logic [DATA_WIDTH-1:0] matrix,
    input logic [1:0]            row,
    input logic [1:0]            col
  );
    logic [SHIFT_WIDTH-1:0] amt;
    logic [DATA_WIDTH-1:0]  shifted;
    amt     = SHIFT_WIDTH'({row, col}) * SHIFT_WIDTH'(VAR_WIDTH);
    shifted = matrix << amt;
    return shifted[DATA_WIDTH-1 -: VAR_WIDTH];
  endfunction

endpackage

// File: rtl/mmac_result_streamer_if.sv
// Handshake bundle between the streamer and its matrix source / element sink.
// Latency: none (wiring only).
// Backpressure: in_ready throttles the matrix source, out_ready stalls the element stream.
// Ports: in_valid/in_ready/in_matrix/in_col_major (matrix side),
//        out_valid/out_ready/out_data/out_row/out_col/out_last (element side).
// slave = the streamer itself; master = the environment around it.
interface mmac_result_streamer_if;
  import mmac_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_matrix;
  logic                  in_col_major;
  logic                  out_valid;
  logic                  out_ready;
  logic [VAR_WIDTH-1:0]  out_data;
  logic [1:0]            out_row;
  logic [1:0]            out_col;
  logic                  out_last;

  modport slave (
    input  in_valid, in_matrix, in_col_major, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_last
  );

  modport master (
    output in_valid, in_matrix, in_col_major, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_last
  );

endinterface

// File: rtl/mmac_matrix_buf.sv
// One matrix holding register: packed matrix + order bit + occupancy flag.
// Latency: contents and valid_o update one cycle after load_i/drop_i.
// Backpressure: none; the owner decides when to load or drop.
// Ports: clock, reset (async active-low), load_i/drop_i controls,
//        matrix_i/col_major_i data in, matrix_o/col_major_o/valid_o state out.
module mmac_matrix_buf
  import mmac_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  drop_i,
  input  logic [DATA_WIDTH-1:0] matrix_i,
  input  logic                  col_major_i,
  output logic [DATA_WIDTH-1:0] matrix_o,
  output logic                  col_major_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] matrix_q;
  logic                  col_major_q;
  logic                  valid_q;
  logic                  valid_d;

  // Payload is never observed while the buffer is empty, so it carries no reset.
  always_ff @(posedge clock) begin
    if (load_i) begin
      matrix_q    <= matrix_i;
      col_major_q <= col_major_i;
    end
  end

  // A load wins over a drop so a reload on the final beat keeps the buffer full.
  always_comb begin
    valid_d = valid_q;
    if (drop_i) valid_d = 1'b0;
    if (load_i) valid_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  assign matrix_o    = matrix_q;
  assign col_major_o = col_major_q;
  assign valid_o     = valid_q;

endmodule

// File: rtl/mmac_result_streamer.sv
// Serialises packed 4x4 result matrices into one element per beat, row- or column-major.
// Latency: first element valid 1 cycle after matrix accept; back-to-back matrices stream with no bubble.
// Backpressure: out_ready=0 holds the current element; in_ready drops while the shadow buffer is full or clear=1.
// Ports: clock, reset (async active-low), clear (sync flush), bus (slave side of mmac_result_streamer_if).
module mmac_result_streamer
  import mmac_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  mmac_result_streamer_if.slave  bus
);

  streamer_state_t       state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;

  logic                  act_load, act_from_sh, act_drop;
  logic                  sh_load, sh_drop;
  logic [DATA_WIDTH-1:0] act_matrix, sh_matrix, act_matrix_in;
  logic                  act_cm, sh_cm, act_cm_in;
  logic                  act_vld, sh_vld;

  logic                  out_valid_w, in_ready_w;
  logic                  beat, in_fire, idx_last;
  logic [1:0]            row_w, col_w;

  assign out_valid_w = (state_q == ST_STREAM) && act_vld;
  assign in_ready_w  = !clear && ((state_q == ST_IDLE) || !sh_vld);
  assign beat        = out_valid_w && bus.out_ready;
  assign in_fire     = bus.in_valid && in_ready_w;
  assign idx_last    = (idx_q == IDX_WIDTH'(M_SIZE * M_SIZE - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    act_load    = 1'b0;
    act_from_sh = 1'b0;
    act_drop    = 1'b0;
    sh_load     = 1'b0;
    sh_drop     = 1'b0;

    if (clear) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      act_drop = 1'b1;
      sh_drop  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_fire) begin
            act_load = 1'b1;
            state_d  = ST_STREAM;
            idx_d    = '0;
          end
        end
        ST_STREAM: begin
          if (beat && idx_last) begin
            idx_d = '0;
            if (sh_vld) begin
              // Queued matrix takes over with no gap.
              act_load    = 1'b1;
              act_from_sh = 1'b1;
              sh_drop     = 1'b1;
            end else if (in_fire) begin
              // Shadow empty: a matrix arriving on the final beat bypasses it.
              act_load = 1'b1;
            end else begin
              state_d  = ST_IDLE;
              act_drop = 1'b1;
            end
          end else begin
            if (beat)    idx_d   = idx_q + 1'b1;
            if (in_fire) sh_load = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign act_matrix_in = act_from_sh ? sh_matrix : bus.in_matrix;
  assign act_cm_in     = act_from_sh ? sh_cm     : bus.in_col_major;

  mmac_matrix_buf u_active (
    .clock       (clock),
    .reset       (reset),
    .load_i      (act_load),
    .drop_i      (act_drop),
    .matrix_i    (act_matrix_in),
    .col_major_i (act_cm_in),
    .matrix_o    (act_matrix),
    .col_major_o (act_cm),
    .valid_o     (act_vld)
  );

  mmac_matrix_buf u_shadow (
    .clock       (clock),
    .reset       (reset),
    .load_i      (sh_load),
    .drop_i      (sh_drop),
    .matrix_i    (bus.in_matrix),
    .col_major_i (bus.in_col_major),
    .matrix_o    (sh_matrix),
    .col_major_o (sh_cm),
    .valid_o     (sh_vld)
  );

  // Column-major just swaps which half of the beat counter picks the row.
  assign row_w = act_cm ? idx_q[1:0] : idx_q[3:2];
  assign col_w = act_cm ? idx_q[3:2] : idx_q[1:0];

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_row   = row_w;
  assign bus.out_col   = col_w;
  assign bus.out_data  = elem_sel(act_matrix, row_w, col_w);
  assign bus.out_last  = out_valid_w && idx_last;

endmodule

// File: tb/tb_mmac_result_streamer.sv
// Bench for mmac_result_streamer: expected element stream kept as a queue of beats.
// Latency: n/a.
// Backpressure: n/a.
module tb_mmac_result_streamer;
  import mmac_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] r;
    logic [1:0] c;
    logic       l;
  } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;

  mmac_result_streamer_if bus ();

  mmac_result_streamer dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  beat_t exp_q[$];
  int    checks = 0;
  int    fails  = 0;

  logic [14:0] obs_vec, exp_vec;
  logic        acc, obs_valid, obs_ready, obs_last;
  logic [7:0]  obs_data;
  logic [1:0]  obs_row, obs_col;

  // Element (r,c) = base + r*4 + c, (0,0) in the MSBs.
  function automatic logic [127:0] make_mat(input int base);
    logic [127:0] m;
    m = '0;
    for (int k = 0; k < 16; k++) m = {m[119:0], 8'(base + k)};
    return m;
  endfunction

  // Append the 16 beats a matrix must produce, in the requested order.
  function automatic void push_matrix(input logic [127:0] m, input logic cm);
    for (int i = 0; i < 16; i++) begin
      beat_t b;
      int r, c;
      r   = cm ? (i % 4) : (i / 4);
      c   = cm ? (i / 4) : (i % 4);
      b.r = 2'(r);
      b.c = 2'(c);
      b.d = 8'(m >> (8 * (15 - (r * 4 + c))));
      b.l = (i == 15);
      exp_q.push_back(b);
    end
  endfunction

  // Drive one cycle, capture observed/expected outputs, advance the model.
  // The stream holds one active matrix plus at most one queued matrix, so a
  // matrix is accepted whenever 16 or fewer beats are still owed.
  task automatic drive_cycle(input logic iv, input logic [127:0] im, input logic icm,
                             input logic ordy, input logic clr);
    logic ev, er;
    bus.in_valid     = iv;
    bus.in_matrix    = im;
    bus.in_col_major = icm;
    bus.out_ready    = ordy;
    clear            = clr;
    #1;
    ev = (exp_q.size() != 0);
    er = !clr && (exp_q.size() <= 16);
    obs_valid = bus.out_valid;
    obs_ready = bus.in_ready;
    obs_last  = bus.out_last;
    obs_data  = bus.out_data;
    obs_row   = bus.out_row;
    obs_col   = bus.out_col;
    obs_vec = {bus.out_valid, bus.in_ready,
               bus.out_valid ? {bus.out_last, bus.out_row, bus.out_col, bus.out_data} : 13'd0};
    exp_vec = {ev, er, ev ? {exp_q[0].l, exp_q[0].r, exp_q[0].c, exp_q[0].d} : 13'd0};
    acc = iv && er;
    if (clr) exp_q.delete();
    else begin
      if (ev && ordy) void'(exp_q.pop_front());
      if (acc) push_matrix(im, icm);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_last} !== 3'b010) begin
      fails++;
      $display("FAIL reset_values: got v/r/l=%b, expected 010", {bus.out_valid, bus.in_ready, bus.out_last});
    end
    @(negedge clock);
    reset = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL reset_idle cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_row_major();
    int nvalid, first_at;
    nvalid = 0; first_at = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      drive_cycle(cyc == 0, make_mat(1), 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL row_major cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec);
      end
      if (obs_valid) begin
        if (first_at < 0) first_at = cyc;
        nvalid++;
        checks++;
        if (obs_data !== 8'(nvalid)) begin
          fails++;
          $display("FAIL row_major_value: got %0d, expected %0d", obs_data, nvalid);
        end
      end
    end
    checks++;
    if (first_at != 1) begin
      fails++;
      $display("FAIL row_major_latency: got %0d cycles, expected 1", first_at);
    end
    checks++;
    if (nvalid != 16) begin
      fails++;
      $display("FAIL row_major_beats: got %0d, expected 16", nvalid);
    end
  endtask

  task automatic test_col_major();
    int tab[16];
    int k;
    tab = '{1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15, 4, 8, 12, 16};
    k = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      drive_cycle(cyc == 0, make_mat(1), 1'b1, 1'b1, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL col_major cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec);
      end
      if (obs_valid && k < 16) begin
        checks++;
        if (obs_data !== 8'(tab[k]) || obs_last !== (k == 15)) begin
          fails++;
          $display("FAIL col_major_value beat %0d: got %0d last %b, expected %0d", k, obs_data, obs_last, tab[k]);
        end
        k++;
      end
    end
    checks++;
    if (k != 16) begin
      fails++;
      $display("FAIL col_major_beats: got %0d, expected 16", k);
    end
  endtask

  task automatic test_backpressure();
    int stall, nbeats;
    logic ordy;
    stall = 0; nbeats = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      ordy = 1'b1;
      if (exp_q.size() == 11 && stall < 3) begin
        ordy = 1'b0;
        stall++;
      end
      drive_cycle(cyc == 0, make_mat(1), 1'b0, ordy, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL backpressure cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec);
      end
      if (!ordy) begin
        checks++;
        if ({obs_valid, obs_data, obs_row, obs_col} !== {1'b1, 8'd6, 2'd1, 2'd1}) begin
          fails++;
          $display("FAIL backpressure_hold: got v=%b d=%0d r=%0d c=%0d, expected 1/6/1/1", obs_valid, obs_data, obs_row, obs_col);
        end
      end else if (obs_valid) begin
        nbeats++;
        checks++;
        if (obs_data !== 8'(nbeats)) begin
          fails++;
          $display("FAIL backpressure_seq: got %0d, expected %0d", obs_data, nbeats);
        end
      end
    end
    checks++;
    if (nbeats != 16 || stall != 3) begin
      fails++;
      $display("FAIL backpressure_count: got %0d beats %0d stalls, expected 16 and 3", nbeats, stall);
    end
  endtask

  task automatic test_back_to_back();
    logic sent_a, sent_b, iv;
    logic [127:0] m;
    int nvalid, run, best, nlast;
    sent_a = 0; sent_b = 0; nvalid = 0; run = 0; best = 0; nlast = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      iv = 1'b0; m = '0;
      if (!sent_a) begin iv = 1'b1; m = make_mat(1); end
      else if (!sent_b && exp_q.size() <= 13) begin iv = 1'b1; m = make_mat(17); end
      drive_cycle(iv, m, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL back_to_back cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec);
      end
      if (acc) begin
        if (!sent_a) sent_a = 1'b1;
        else         sent_b = 1'b1;
      end
      if (obs_valid) begin
        nvalid++; run++;
        if (run > best) best = run;
        if (obs_last) nlast++;
      end else run = 0;
    end
    checks++;
    if (nvalid != 32 || best != 32 || nlast != 2) begin
      fails++;
      $display("FAIL back_to_back_run: got %0d beats run %0d lasts %0d, expected 32/32/2", nvalid, best, nlast);
    end
  endtask

  task automatic test_last_bypass();
    logic sent_a, sent_b, iv, chk_next;
    logic [127:0] m;
    sent_a = 0; sent_b = 0; chk_next = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      iv = 1'b0; m = '0;
      if (!sent_a) begin iv = 1'b1; m = make_mat(1); end
      else if (!sent_b && exp_q.size() == 1) begin iv = 1'b1; m = make_mat(17); end
      drive_cycle(iv, m, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL last_bypass cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec);
      end
      if (chk_next) begin
        checks++;
        if ({obs_valid, obs_ready, obs_data, obs_row, obs_col} !== {1'b1, 1'b1, 8'd17, 2'd0, 2'd0}) begin
          fails++;
          $display("FAIL last_bypass_first: got v=%b rdy=%b d=%0d r=%0d c=%0d, expected 1/1/17/0/0", obs_valid, obs_ready, obs_data, obs_row, obs_col);
        end
        chk_next = 1'b0;
      end
      if (acc) begin
        if (!sent_a) sent_a = 1'b1;
        else begin sent_b = 1'b1; chk_next = 1'b1; end
      end
    end
    checks++;
    if (!sent_b) begin
      fails++;
      $display("FAIL last_bypass_accept: got no accept of second matrix, expected one");
    end
  endtask

  task automatic test_clear();
    logic sent_a, sent_b, cleared, after, iv, clr;
    logic [127:0] m;
    sent_a = 0; sent_b = 0; cleared = 0; after = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      iv = 1'b0; m = '0; clr = 1'b0;
      if (!sent_a) begin iv = 1'b1; m = make_mat(1); end
      else if (!sent_b && exp_q.size() <= 14) begin iv = 1'b1; m = make_mat(17); end
      else if (!cleared && exp_q.size() == 25) begin clr = 1'b1; iv = 1'b1; m = make_mat(33); end
      drive_cycle(iv, m, 1'b0, 1'b1, clr);
      checks++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL clear cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec);
      end
      if (after) begin
        checks++;
        if ({obs_valid, obs_ready} !== 2'b01) begin
          fails++;
          $display("FAIL clear_after: got v/rdy=%b, expected 01", {obs_valid, obs_ready});
        end
        after = 1'b0;
      end
      if (clr) begin cleared = 1'b1; after = 1'b1; end
      if (acc) begin
        if (!sent_a) sent_a = 1'b1;
        else         sent_b = 1'b1;
      end
    end
    checks++;
    if (!cleared) begin
      fails++;
      $display("FAIL clear_reached: got no clear at beat 7 with queue full, expected one");
    end
  endtask

  task automatic test_reset_mid();
    logic sent_a;
    int guard;
    sent_a = 0; guard = 0;
    while (!(sent_a && exp_q.size() == 7) && guard < 30) begin
      drive_cycle(!sent_a, make_mat(1), 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL reset_mid_pre cyc %0d: got %h, expected %h", guard, obs_vec, exp_vec);
      end
      if (acc) sent_a = 1'b1;
      guard++;
    end
    checks++;
    if (guard >= 30) begin
      fails++;
      $display("FAIL reset_mid_timeout: got %0d cycles, expected beat 9 within 30", guard);
    end
    bus.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_last} !== 3'b010) begin
      fails++;
      $display("FAIL reset_mid_async: got v/r/l=%b, expected 010", {bus.out_valid, bus.in_ready, bus.out_last});
    end
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    for (int cyc = 0; cyc < 25; cyc++) begin
      drive_cycle(cyc == 6, make_mat(101), 1'b1, 1'b1, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL reset_mid_post cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 500; cyc++) begin
      drive_cycle($urandom_range(0, 1) == 1, {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 59) == 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL random cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec);
      end
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL random_drain cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_matrix    = '0;
    bus.in_col_major = 1'b0;
    bus.out_ready    = 1'b0;
    @(negedge clock);
    test_reset();
    test_row_major();
    test_col_major();
    test_backpressure();
    test_back_to_back();
    test_last_bypass();
    test_clear();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
